sys_array_host_driver: RTL and testbench

- Host-side stream endpoint for the systolic array. It is the initiator of the operand stream and the receiver of the result stream.
- Holds A (MxN) and B (NxK) operand words in a local buffer written by the host. On start it transmits them as AXI-Stream beats of BW 32-bit words into the array's input port.
- It then accepts the MxK result beats from the array's output port into a readable result buffer and pulses done.

---
 rtl/sys_array_host_driver.sv | 193 +++++++++++++++++++
 tb/tb_sys_array_host_driver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_host_driver.sv
// sys_array_host_driver: host-side endpoint for the systolic array.
// Buffers A/B operand words written by the host, streams them out as beats
// of BW 32-bit words, then collects the result beats into a readable buffer
// and pulses done. Define SYS_DRV_TIMEOUT_EN to enable the RECV idle timeout.
module sys_array_host_driver #(
   parameter int M       = 2,
   parameter int N       = 2,
   parameter int K       = 2,
   parameter int BW      = 2,
   parameter int TIMEOUT = 1024,
   localparam int OPW    = M*N + K*N,
   localparam int RSW    = M*K,
   localparam int OPAW   = (OPW > 1) ? $clog2(OPW) : 1,
   localparam int RSAW   = (RSW > 1) ? $clog2(RSW) : 1,
   localparam int SW     = 32*BW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   input  logic            op_wr_en,
   input  logic [OPAW-1:0] op_wr_addr,
   input  logic [31:0]     op_wr_dat,
   input  logic [RSAW-1:0] res_rd_addr,
   output logic [31:0]     res_rd_dat,
   output logic [SW-1:0]   out_stream,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic [SW-1:0]   in_stream,
   input  logic            in_valid,
   output logic            in_ready
);

   localparam int OPB  = (OPW + BW - 1) / BW;
   localparam int RSB  = (RSW + BW - 1) / BW;
   localparam int MAXB = (OPB > RSB) ? OPB : RSB;
   localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;

   // A bad configuration is caught at elaboration rather than producing odd beats.
   if (BW < 1 || BW > 8 || TIMEOUT < 1) begin : gParamCheck
      $error("sys_array_host_driver: BW must be 1..8 and TIMEOUT must be positive");
   end

   typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

   state_t          state_q, state_d;
   logic [BCW-1:0]  beatCnt_q, beatCnt_d;
   logic [SW-1:0]   outBeat_q, outBeat_d;
   logic [BCW-1:0]  packIdx;
   logic [SW-1:0]   packedBeat;
   logic [31:0]     opBuf  [OPW];
   logic [31:0]     resBuf [RSW];

`ifdef SYS_DRV_TIMEOUT_EN
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TCW-1:0]  idleCnt_q, idleCnt_d;
   logic            err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Gather the BW operand words of beat packIdx; lanes past the last word stay zero.
   always_comb begin
      packedBeat = '0;
      for (int w = 0; w < BW; w++) begin
         if (int'(packIdx) * BW + w < OPW) begin
            packedBeat[32*w +: 32] = opBuf[OPAW'(int'(packIdx) * BW + w)];
         end
      end
   end

   // Next-state and handshake logic; the next outgoing beat is preloaded so out_stream is always a register.
   always_comb begin
      state_d   = state_q;
      beatCnt_d = beatCnt_q;
      outBeat_d = outBeat_q;
      packIdx   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      in_ready  = 1'b0;
`ifdef SYS_DRV_TIMEOUT_EN
      idleCnt_d = idleCnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SEND;
               beatCnt_d = '0;
               outBeat_d = packedBeat;
`ifdef SYS_DRV_TIMEOUT_EN
               err_d     = 1'b0;
               idleCnt_d = '0;
`endif
            end
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            packIdx   = beatCnt_q + BCW'(1);
            if (out_ready) begin
               if (beatCnt_q == BCW'(OPB - 1)) begin
                  state_d   = RECV;
                  beatCnt_d = '0;
                  outBeat_d = '0;
`ifdef SYS_DRV_TIMEOUT_EN
                  idleCnt_d = '0;
`endif
               end else begin
                  beatCnt_d = beatCnt_q + BCW'(1);
                  outBeat_d = packedBeat;
               end
            end
         end
         RECV: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef SYS_DRV_TIMEOUT_EN
               idleCnt_d = '0;
`endif
               if (beatCnt_q == BCW'(RSB - 1)) begin
                  state_d   = DONE;
                  beatCnt_d = '0;
               end else begin
                  beatCnt_d = beatCnt_q + BCW'(1);
               end
            end
`ifdef SYS_DRV_TIMEOUT_EN
            else if (idleCnt_q == TCW'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               beatCnt_d = '0;
               err_d     = 1'b1;
            end else begin
               idleCnt_d = idleCnt_q + TCW'(1);
            end
`endif
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous reset; the buffers are deliberately left alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         beatCnt_q <= '0;
         outBeat_q <= '0;
`ifdef SYS_DRV_TIMEOUT_EN
         idleCnt_q <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         beatCnt_q <= beatCnt_d;
         outBeat_q <= outBeat_d;
`ifdef SYS_DRV_TIMEOUT_EN
         idleCnt_q <= idleCnt_d;
         err_q     <= err_d;
`endif
      end
   end

   // Host operand writes land only while idle so a transfer in flight sees a frozen buffer.
   always_ff @(posedge clk) begin
      if (op_wr_en && state_q == IDLE && int'(op_wr_addr) < OPW) begin
         opBuf[op_wr_addr] <= op_wr_dat;
      end
   end

   // Each accepted result beat scatters its lanes to beat*BW onward, dropping lanes past M*K.
   always_ff @(posedge clk) begin
      if (!rst && state_q == RECV && in_valid) begin
         for (int w = 0; w < BW; w++) begin
            if (int'(beatCnt_q) * BW + w < RSW) begin
               resBuf[RSAW'(int'(beatCnt_q) * BW + w)] <= in_stream[32*w +: 32];
            end
         end
      end
   end

   assign out_stream = outBeat_q;
   assign res_rd_dat = (int'(res_rd_addr) < RSW) ? resBuf[res_rd_addr] : 32'h0;

endmodule

// File: tb/tb_sys_array_host_driver.sv
// Self-checking bench for sys_array_host_driver: a 2x2x2 instance with BW=2
// exercises streaming, stalls, reset and the RECV wait; a 3x3x3 instance
// exercises the partial final result beat.
module tb_sys_array_host_driver;

   localparam int M = 2, N = 2, K = 2, BW = 2, TOUT = 16;
   localparam int OPW = 8, RSW = 4, OPB = 4;
   localparam int OPW3 = 18, RSW3 = 9, OPB3 = 9, RSB3 = 5;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, err;
   logic        opWrEn;
   logic [2:0]  opWrAddr;
   logic [31:0] opWrDat, resRdDat;
   logic [1:0]  resRdAddr;
   logic [63:0] outStream, inStream;
   logic        outValid, outReady, inValid, inReady;

   logic        s3Start, s3Busy, s3Done, s3Err, s3OpWrEn;
   logic [4:0]  s3OpWrAddr;
   logic [31:0] s3OpWrDat, s3ResRdDat;
   logic [3:0]  s3ResRdAddr;
   logic [63:0] s3OutStream, s3InStream;
   logic        s3OutValid, s3OutReady, s3InValid, s3InReady;

   int nCompared = 0, nMismatch = 0;
   int hsCount = 0, doneCount = 0, s3Hs = 0;
   logic [63:0] expQ[$], capQ[$], expQ3[$];
   logic [31:0] opModel [OPW];
   logic        prevStall = 1'b0;
   logic [63:0] prevStream;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] expData;
   } readVec_t;
   readVec_t readTab [RSW];

   always #5 clk = ~clk;

   sys_array_host_driver #(.M(M), .N(N), .K(K), .BW(BW), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .op_wr_en(opWrEn), .op_wr_addr(opWrAddr), .op_wr_dat(opWrDat),
      .res_rd_addr(resRdAddr), .res_rd_dat(resRdDat),
      .out_stream(outStream), .out_valid(outValid), .out_ready(outReady),
      .in_stream(inStream), .in_valid(inValid), .in_ready(inReady)
   );

   sys_array_host_driver #(.M(3), .N(3), .K(3), .BW(2), .TIMEOUT(TOUT)) dut3 (
      .clk(clk), .rst(rst), .start(s3Start), .busy(s3Busy), .done(s3Done), .err(s3Err),
      .op_wr_en(s3OpWrEn), .op_wr_addr(s3OpWrAddr), .op_wr_dat(s3OpWrDat),
      .res_rd_addr(s3ResRdAddr), .res_rd_dat(s3ResRdDat),
      .out_stream(s3OutStream), .out_valid(s3OutValid), .out_ready(s3OutReady),
      .in_stream(s3InStream), .in_valid(s3InValid), .in_ready(s3InReady)
   );

   // Compare one observed value against its required value and tally the result.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL %s: event did not occur within its bound", name);
   endtask

   function automatic logic [63:0] expBeat(input int b);
      logic [63:0] r = '0;
      for (int w = 0; w < BW; w++)
         if (b * BW + w < OPW) r[32*w +: 32] = opModel[b * BW + w];
      return r;
   endfunction

   function automatic logic [31:0] op3(input int i);
      return 32'h3000_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] res3(input int i);
      return (i < RSW3) ? 32'h5000_0000 + 32'(i) : 32'hFFFF_FFFF;
   endfunction

   // Operand-stream monitor for the 2x2 instance: scoreboard pops, stall hold and AXI side checks.
   always @(negedge clk) begin
      if (rst) begin
         prevStall = 1'b0;
      end else begin
         if (outValid) begin
            checkOutput("busyWhileSending", busy, 1);
            checkOutput("inReadyLowInSend", inReady, 0);
         end
         if (prevStall && outValid) checkOutput("stallHold", outStream, prevStream);
         if (outValid && outReady) begin
            hsCount++;
            capQ.push_back(outStream);
            if (expQ.size() == 0) failNow("unexpectedOperandBeat");
            else checkOutput("operandBeat", outStream, expQ.pop_front());
         end
         prevStall  = outValid && !outReady;
         prevStream = outStream;
         if (done) doneCount++;
      end
   end

   // Operand-stream monitor for the 3x3 instance.
   always @(negedge clk) begin
      if (!rst && s3OutValid && s3OutReady) begin
         s3Hs++;
         if (expQ3.size() == 0) failNow("unexpectedOperandBeat3");
         else checkOutput("operandBeat3", s3OutStream, expQ3.pop_front());
      end
   end

   task automatic applyReset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic applyWrite(input logic [2:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      opWrEn = 1'b1; opWrAddr = addr; opWrDat = data;
      opModel[addr] = data;
      @(posedge clk); #1;
      opWrEn = 1'b0;
   endtask

   task automatic applyStart();
      @(posedge clk); #1;
      start = 1'b1;
      for (int b = 0; b < OPB; b++) expQ.push_back(expBeat(b));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitHs(input int target, input string name);
      for (int c = 0; c < 200 && hsCount < target; c++) begin
         @(posedge clk); #1;
      end
      if (hsCount < target) failNow(name);
   endtask

   task automatic applyResult(input logic [63:0] data, input int gap);
      int c = 0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      inValid = 1'b1; inStream = data;
      while (!inReady && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      if (!inReady) failNow("resultHandshake");
      @(posedge clk); #1;
      inValid = 1'b0; inStream = '0;
   endtask

   task automatic checkReads(input string name);
      for (int r = 0; r < RSW; r++) begin
         resRdAddr = readTab[r].addr;
         #1 checkOutput(name, resRdDat, readTab[r].expData);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] opInit [OPW];
      logic [3:0]  readyPat;
      int hsBase, doneBase;

      opInit = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      readTab[0] = '{addr: 2'd0, expData: 32'h41980000};
      readTab[1] = '{addr: 2'd1, expData: 32'h41B00000};
      readTab[2] = '{addr: 2'd2, expData: 32'h422C0000};
      readTab[3] = '{addr: 2'd3, expData: 32'h42480000};
      readyPat = 4'b1001;

      rst = 1'b1; start = 1'b0; opWrEn = 1'b0; opWrAddr = '0; opWrDat = '0;
      resRdAddr = '0; outReady = 1'b0; inValid = 1'b0; inStream = '0;
      s3Start = 1'b0; s3OpWrEn = 1'b0; s3OpWrAddr = '0; s3OpWrDat = '0;
      s3ResRdAddr = '0; s3OutReady = 1'b0; s3InValid = 1'b0; s3InStream = '0;

      // Reset state
      applyReset();
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetErr", err, 0);
      checkOutput("resetOutValid", outValid, 0);
      checkOutput("resetInReady", inReady, 0);
      checkOutput("resetOutStream", outStream, 0);
      checkOutput("resetBusy3", s3Busy, 0);
      checkOutput("resetOutStream3", s3OutStream, 0);

      // Full transfer with out_ready held high
      for (int i = 0; i < OPW; i++) applyWrite(3'(i), opInit[i]);
      outReady = 1'b1;
      capQ.delete();
      applyStart();
      checkOutput("firstBeatLatency", outValid, 1);
      checkOutput("busyAfterStart", busy, 1);
      waitHs(4, "fourOperandBeats");
      outReady = 1'b0;
      checkOutput("outValidDropsInRecv", outValid, 0);
      checkOutput("inReadyInRecv", inReady, 1);
      checkOutput("busyInRecv", busy, 1);
      checkOutput("firstBeatValue", capQ[0], 64'h40000000_3F800000);
      checkOutput("lastBeatValue", capQ[3], 64'h41000000_40E00000);
      doneBase = doneCount;
      applyResult({32'h41B00000, 32'h41980000}, 1);
      checkOutput("doneLowMidRecv", done, 0);
      applyResult({32'h42480000, 32'h422C0000}, 2);
      checkOutput("donePulse", done, 1);
      checkOutput("busyLowInDone", busy, 0);
      @(posedge clk); #1;
      checkOutput("doneOneCycle", done, 0);
      repeat (3) @(posedge clk);
      #1 checkOutput("doneCountOnce", doneCount - doneBase, 1);
      checkReads("resultRead");

      // Stalled transfer, plus an operand write attempted while busy
      hsBase = hsCount;
      applyStart();
      opWrEn = 1'b1; opWrAddr = 3'd0; opWrDat = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      opWrEn = 1'b0;
      for (int c = 0; c < 64 && hsCount - hsBase < 4; c++) begin
         outReady = readyPat[3 - (c % 4)];
         @(posedge clk); #1;
      end
      outReady = 1'b0;
      repeat (3) @(posedge clk);
      #1 checkOutput("stallHandshakeCount", hsCount - hsBase, 4);
      checkOutput("stallEndsInRecv", inReady, 1);
      applyResult({32'h41B00000, 32'h41980000}, 0);
      applyResult({32'h42480000, 32'h422C0000}, 1);
      repeat (2) @(posedge clk);

      // Result beats offered while idle must be refused
      #1 inValid = 1'b1; inStream = '1;
      repeat (3) @(posedge clk);
      #1 checkOutput("inReadyLowInIdle", inReady, 0);
      inValid = 1'b0; inStream = '0;
      checkReads("idleBeatIgnored");

      // Reset in SEND after beat 1, then a fresh start from beat 0
      hsBase = hsCount;
      outReady = 1'b1;
      applyStart();
      waitHs(hsBase + 2, "twoBeatsBeforeReset");
      rst = 1'b1; outReady = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      checkOutput("rstOutValid", outValid, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstInReady", inReady, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstOutStream", outStream, 0);
      checkReads("resultKeptOverReset");
      outReady = 1'b1;
      capQ.delete();
      applyStart();
      waitHs(hsBase + 6, "resendAfterReset");
      outReady = 1'b0;
      checkOutput("resendBeat0", capQ[0], 64'h40000000_3F800000);
      checkOutput("resendRecv", inReady, 1);

      // Start while busy is ignored
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("startIgnoredInReady", inReady, 1);
      checkOutput("startIgnoredOutValid", outValid, 0);

      // RECV with no result beats
      doneBase = doneCount;
      repeat (30) @(posedge clk);
`ifdef SYS_DRV_TIMEOUT_EN
      #1 checkOutput("timeoutErr", err, 1);
      checkOutput("timeoutIdle", busy, 0);
      checkOutput("timeoutNoDone", doneCount - doneBase, 0);
      applyStart();
      checkOutput("startClearsErr", err, 0);
`else
      #1 checkOutput("recvWaitsBusy", busy, 1);
      checkOutput("recvWaitsErr", err, 0);
      checkOutput("recvWaitsNoDone", doneCount - doneBase, 0);
`endif
      applyReset();
      expQ.delete();
      checkOutput("rstFromRecvBusy", busy, 0);

      // 3x3x3 instance: 9 operand beats, 5 result beats with a discarded upper lane
      for (int i = 0; i < OPW3; i++) begin
         @(posedge clk); #1;
         s3OpWrEn = 1'b1; s3OpWrAddr = 5'(i); s3OpWrDat = op3(i);
      end
      @(posedge clk); #1;
      s3OpWrEn = 1'b0;
      s3OutReady = 1'b1;
      s3Start = 1'b1;
      for (int b = 0; b < OPB3; b++) expQ3.push_back({op3(2*b + 1), op3(2*b)});
      @(posedge clk); #1;
      s3Start = 1'b0;
      for (int c = 0; c < 100 && s3Hs < OPB3; c++) begin
         @(posedge clk); #1;
      end
      if (s3Hs < OPB3) failNow("nineOperandBeats3");
      s3OutReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 checkOutput("beatCount3", s3Hs, OPB3);
      checkOutput("recv3", s3InReady, 1);
      for (int b = 0; b < RSB3; b++) begin
         s3InValid = 1'b1; s3InStream = {res3(2*b + 1), res3(2*b)};
         @(posedge clk); #1;
         s3InValid = 1'b0;
         if (b < RSB3 - 1) checkOutput("noEarlyDone3", s3Done, 0);
      end
      checkOutput("done3", s3Done, 1);
      for (int r = 0; r < RSW3; r++) begin
         s3ResRdAddr = 4'(r);
         #1 checkOutput("resultRead3", s3ResRdDat, res3(r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
